multiplier_unit: RTL

- Iterative RV32M multiplier in the EXECUTE stage; executes MUL, MULH, MULHSU and MULHU.
- Drives mult_ready, which the hazard unit combines with d2eif_mult to stall fetch, decode and execute while a multiply is in flight.
- Holds its result until the pipeline actually advances, so memory-side stalls do not lose it.

---
 rtl/common_types_pkg.sv | 18 +
 rtl/multiplier_unit_if.sv | 29 ++
 rtl/mult_step.sv | 19 +
 rtl/multiplier_unit.sv | 127 ++++++++++++
 4 files changed

// File: rtl/common_types_pkg.sv
// Shared types for the EXECUTE-stage multiplier: op encoding and FSM states.
package common_types_pkg;

  // Encoding matches funct3[1:0] of the RV32M multiply instructions
  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mult_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/multiplier_unit_if.sv
// Bundle of the multiplier_unit port list, with design-side and bench-side views.
interface multiplier_unit_if
  import common_types_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input logic CLK
);
  logic              RST;
  logic              mult_start;
  mult_op_t          mult_op;
  logic [DATA_W-1:0] mult_a;
  logic [DATA_W-1:0] mult_b;
  logic              mult_advance;
  logic              mult_flush;
  logic              mult_ready;
  logic              mult_busy;
  logic [DATA_W-1:0] mult_out;

  modport multiplier_unit (
    input  CLK, RST, mult_start, mult_op, mult_a, mult_b, mult_advance, mult_flush,
    output mult_ready, mult_busy, mult_out
  );

  modport tb (
    input  CLK, mult_ready, mult_busy, mult_out,
    output RST, mult_start, mult_op, mult_a, mult_b, mult_advance, mult_flush
  );
endinterface

// File: rtl/mult_step.sv
// One radix-2^STEP_BITS partial-product step: acc + (a * chunk) << shamt.
module mult_step #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned STEP_BITS = 2,
  parameter int unsigned SH_W      = $clog2(2 * DATA_W)
) (
  input  logic [2*DATA_W-1:0] i_acc,
  input  logic [DATA_W-1:0]   i_a,
  input  logic [STEP_BITS-1:0] i_chunk,
  input  logic [SH_W-1:0]     i_shamt,
  output logic [2*DATA_W-1:0] o_acc_c
);
  localparam int unsigned ACC_W = 2 * DATA_W;

  logic [ACC_W-1:0] w_prod;

  assign w_prod  = ACC_W'(i_a) * ACC_W'(i_chunk);
  assign o_acc_c = i_acc + (w_prod << i_shamt);
endmodule

// File: rtl/multiplier_unit.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) for EXECUTE; result held
// in DONE until the pipeline advances so memory-side stalls cannot drop it.
module multiplier_unit
  import common_types_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned STEP_BITS = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              mult_start,
  input  mult_op_t          mult_op,
  input  logic [DATA_W-1:0] mult_a,
  input  logic [DATA_W-1:0] mult_b,
  input  logic              mult_advance,
  input  logic              mult_flush,
  output logic              mult_ready,
  output logic              mult_busy,
  output logic [DATA_W-1:0] mult_out
);
  localparam int unsigned ITERS = DATA_W / STEP_BITS;
  localparam int unsigned ACC_W = 2 * DATA_W;
  localparam int unsigned CNT_W = $clog2(ITERS + 1);
  localparam int unsigned SH_W  = $clog2(ACC_W);

  mult_state_t       r_state, w_state_nxt;
  mult_op_t          r_op;
  logic [DATA_W-1:0] r_a, r_b;
  logic              r_neg;
  logic [CNT_W-1:0]  r_cnt;
  logic [ACC_W-1:0]  r_acc;
  logic              r_ready, r_busy;
  logic [DATA_W-1:0] r_out;

  logic              w_sign_a, w_sign_b;
  logic [DATA_W-1:0] w_abs_a, w_abs_b;
  logic              w_accept, w_step_en;
  logic [SH_W-1:0]   w_shamt;
  logic [ACC_W-1:0]  w_acc_step;
  logic [ACC_W-1:0]  w_res;
  logic [DATA_W-1:0] w_fin;
  logic              w_ready_nxt, w_busy_nxt;
  logic [DATA_W-1:0] w_out_nxt;

  // Only operands the op treats as signed contribute a sign
  assign w_sign_a = ((mult_op == MULH) || (mult_op == MULHSU)) && mult_a[DATA_W-1];
  assign w_sign_b = (mult_op == MULH) && mult_b[DATA_W-1];
  assign w_abs_a  = w_sign_a ? (DATA_W'(0) - mult_a) : mult_a;
  assign w_abs_b  = w_sign_b ? (DATA_W'(0) - mult_b) : mult_b;

  assign w_shamt = SH_W'(r_cnt) * SH_W'(STEP_BITS);
  assign w_res   = r_neg ? (ACC_W'(0) - r_acc) : r_acc;
  assign w_fin   = (r_op == MUL) ? w_res[DATA_W-1:0] : w_res[ACC_W-1:DATA_W];

  mult_step #(
    .DATA_W   (DATA_W),
    .STEP_BITS(STEP_BITS),
    .SH_W     (SH_W)
  ) u_step (
    .i_acc  (r_acc),
    .i_a    (r_a),
    .i_chunk(r_b[STEP_BITS-1:0]),
    .i_shamt(w_shamt),
    .o_acc_c(w_acc_step)
  );

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Flush overrides everything, including start and advance
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (mult_start) w_state_nxt = BUSY;
      BUSY:    if (r_cnt == CNT_W'(ITERS)) w_state_nxt = DONE;
      DONE:    if (mult_advance) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (mult_flush) w_state_nxt = IDLE;
  end

  always_comb begin
    w_accept    = (r_state == IDLE) && (w_state_nxt == BUSY);
    w_step_en   = (r_state == BUSY) && (w_state_nxt == BUSY);
    w_ready_nxt = (w_state_nxt == DONE);
    w_busy_nxt  = (w_state_nxt != IDLE);
    w_out_nxt   = r_out;
    if ((r_state == BUSY) && (w_state_nxt == DONE)) w_out_nxt = w_fin;
    else if (w_state_nxt == IDLE)                   w_out_nxt = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_op    <= MUL;
      r_a     <= '0;
      r_b     <= '0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_out   <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= mult_op;
        r_a   <= w_abs_a;
        r_b   <= w_abs_b;
        r_neg <= w_sign_a ^ w_sign_b;
        r_cnt <= '0;
        r_acc <= '0;
      end else if (w_step_en) begin
        r_acc <= w_acc_step;
        r_b   <= r_b >> STEP_BITS;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_out   <= w_out_nxt;
    end
  end

  assign mult_ready = r_ready;
  assign mult_busy  = r_busy;
  assign mult_out   = r_out;
endmodule
